// File: rtl/pwm_multichannel_if.sv
// Register-write bus for the PWM engine: a one-cycle write strobe with an
// address and a data byte.
interface pwm_multichannel_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM engine with an internal register file.
// Each channel has a shadow duty register that is copied into the active duty
// register only at a period boundary, so the outputs never glitch mid-period.
// A shared prescaler and counter support edge-aligned and center-aligned modes.
module pwm_multichannel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_multichannel_if.slave  bus,
  input  logic [NUM_CH-1:0]  out_en,
  input  logic [NUM_CH-1:0]  pwm_en,
  output logic [NUM_CH-1:0]  out,
  output logic               period_tick
);

  localparam logic [CNT_W-1:0] TOP        = {CNT_W{1'b1}};
  localparam logic [6:0]       ADDR_PRESC = 7'h7E;
  localparam logic [6:0]       ADDR_CTRL  = 7'h7F;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [CNT_W-1:0]   duty_shadow_q [NUM_CH];
  logic [CNT_W-1:0]   duty_shadow_d [NUM_CH];
  logic [CNT_W-1:0]   duty_active_q [NUM_CH];
  logic [CNT_W-1:0]   duty_active_d [NUM_CH];
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [1:0]         ctrl_q, ctrl_d;        // bit0 center_mode, bit1 run
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               period_tick_q, period_tick_d;

  logic               run, center, wr_presc, wr_ctrl, tick;
  logic [CNT_W-1:0]   cnt_step;
  dir_e               dir_step;
  logic [NUM_CH-1:0]  raw;

  assign run      = ctrl_q[1];
  assign center   = ctrl_q[0];
  assign wr_presc = bus.wr_en && (bus.wr_addr == ADDR_PRESC);
  assign wr_ctrl  = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  assign tick     = run && (presc_cnt_q == presc_q);

  // Counter value and direction that the next tick would produce.
  always_comb begin
    cnt_step = cnt_q + 1'b1;   // edge mode wraps TOP -> 0 naturally
    dir_step = DIR_UP;
    if (center) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q == TOP) begin
          cnt_step = TOP - 1'b1;
          dir_step = DIR_DOWN;
        end
      end else begin
        cnt_step = cnt_q - 1'b1;
        dir_step = DIR_DOWN;
      end
      if (cnt_step == '0) dir_step = DIR_UP;
    end
  end

  // Register file, prescaler, counter and duty-update control.
  always_comb begin
    duty_shadow_d = duty_shadow_q;
    duty_active_d = duty_active_q;
    presc_d       = presc_q;
    presc_cnt_d   = presc_cnt_q;
    ctrl_d        = ctrl_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    period_tick_d = 1'b0;

    if (run) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) begin
        cnt_d = cnt_step;
        dir_d = dir_step;
        if (cnt_step == '0) begin
          // Period boundary: load the pre-write shadow values.
          duty_active_d = duty_shadow_q;
          period_tick_d = 1'b1;
        end
      end
    end else begin
      presc_cnt_d   = '0;
      cnt_d         = '0;
      dir_d         = DIR_UP;
      duty_active_d = duty_shadow_q;
    end

    if (wr_presc) begin
      presc_d = bus.wr_data[PRESC_W-1:0];
      // Compare with the advanced count so a shrinking prescale never
      // leaves the count beyond the new terminal value.
      if (bus.wr_data[PRESC_W-1:0] < presc_cnt_d) presc_cnt_d = '0;
    end

    if (wr_ctrl) begin
      ctrl_d        = bus.wr_data[1:0];
      presc_cnt_d   = '0;
      cnt_d         = '0;
      dir_d         = DIR_UP;
      duty_active_d = duty_shadow_q;
      period_tick_d = 1'b0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.wr_en && (bus.wr_addr == 7'(i))) duty_shadow_d[i] = bus.wr_data[CNT_W-1:0];
    end
  end

  // Per-channel compare and output gating.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign raw[gi]   = run && ((duty_active_q[gi] == TOP) || (cnt_q < duty_active_q[gi]));
    assign out_d[gi] = out_en[gi] & (pwm_en[gi] ? raw[gi] : 1'b1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shadow_q[i] <= '0;
        duty_active_q[i] <= '0;
      end
      presc_q       <= '0;
      presc_cnt_q   <= '0;
      ctrl_q        <= 2'b10;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      out_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      duty_active_q <= duty_active_d;
      presc_q       <= presc_d;
      presc_cnt_q   <= presc_cnt_d;
      ctrl_q        <= ctrl_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      out_q         <= out_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign out         = out_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomised bench for pwm_multichannel against a time-based reference model:
// the expected counter value is derived from the number of clocks since the
// last restart, the prescale and the mode, using plain arithmetic.
module tb_pwm_multichannel;
  localparam int N   = 16;
  localparam int TOP = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] out_en, pwm_en, out;
  logic         period_tick;

  pwm_multichannel_if bus ();

  pwm_multichannel #(.NUM_CH(N), .CNT_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .out_en(out_en), .pwm_en(pwm_en), .out(out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit m_run, m_center;
  int m_p, m_t;
  int m_shadow [N];
  int m_active [N];
  bit obs_ptick, obs_out0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_init();
    m_run = 1; m_center = 0; m_p = 0; m_t = 0;
    for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
  endfunction

  function automatic int period_len();
    return m_center ? 2 * TOP : TOP + 1;
  endfunction

  function automatic int model_cnt();
    int n, k;
    n = m_t / (m_p + 1);
    k = n % period_len();
    return (m_center && k > TOP) ? period_len() - k : k;
  endfunction

  function automatic bit model_update_next();
    int t1;
    if (!m_run) return 0;
    t1 = m_t + 1;
    return (t1 % (m_p + 1) == 0) && (((t1 / (m_p + 1)) % period_len()) == 0);
  endfunction

  // One clock: drive a (possibly idle) write, advance the model, check outputs.
  task automatic cyc(input bit we = 0, input int addr = 0, input int data = 0);
    logic [N-1:0] eo;
    bit ep;
    int c;
    bus.wr_en   = we;
    bus.wr_addr = 7'(addr);
    bus.wr_data = 8'(data);
    c = model_cnt();
    for (int i = 0; i < N; i++)
      eo[i] = out_en[i] & (pwm_en[i] ? (m_run && (m_active[i] == TOP || c < m_active[i])) : 1'b1);
    ep = 0;
    if (we && addr == 127) begin
      m_run = data[1]; m_center = data[0]; m_t = 0;
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    end else if (m_run) begin
      ep = model_update_next();
      m_t++;
      if (ep) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    end else begin
      m_t = 0;
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    end
    if (we && addr < N) m_shadow[addr] = data & 255;
    if (we && addr == 126) m_p = data & 255;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    check_val("out", out, eo);
    check_val("ptick", period_tick, ep);
    obs_ptick = period_tick;
    obs_out0  = out[0];
  endtask

  // Sync to a period_tick, then measure period length and ch0 high time.
  task automatic measure(input string tag, input int exp_per, input int exp_hi);
    int n, hi;
    n = 0; hi = 0;
    while (!obs_ptick && n < 5000) begin cyc(); n++; end
    check_val({tag, "_sync"}, obs_ptick, 1);
    n = 0;
    do begin cyc(); n++; hi += obs_out0; end while (!obs_ptick && n < 5000);
    check_val({tag, "_per"}, n, exp_per);
    check_val({tag, "_hi"}, hi, exp_hi);
  endtask

  task automatic count_to_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!obs_ptick && n < 5000);
    check_val(tag, n, exp_n);
  endtask

  initial begin
    int k, r, ch, v;
    out_en = '0; pwm_en = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    obs_ptick = 0; obs_out0 = 0;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", out, 0);
    check_val("reset_ptick", period_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge mode, duty 0x40, presc 0.
    out_en[0] = 1; pwm_en[0] = 1;
    cyc(1, 0, 8'h40);
    measure("edge", 256, 64);
    measure("edge2", 256, 64);

    // Boundary channels.
    out_en[4:1] = 4'b0111; pwm_en[4:1] = 4'b1011;
    cyc(1, 1, 8'h00);
    cyc(1, 2, 8'hFF);
    cyc(1, 4, 8'h80);
    repeat (600) cyc();

    // Shadow update mid-period, then coincident with the update event.
    repeat (100) cyc();
    cyc(1, 0, 8'hC0);
    measure("shadow", 256, 192);
    k = 0;
    while (!model_update_next() && k < 5000) begin cyc(); k++; end
    cyc(1, 0, 8'h20);
    measure("coinc_old", 256, 192);
    measure("coinc_new", 256, 32);

    // Prescaler 3, center mode.
    cyc(1, 127, 0);
    cyc(1, 126, 3);
    cyc(1, 0, 8'h40);
    cyc(1, 127, 3);
    measure("center", 2040, 508);

    // Run off, then restart in edge mode.
    cyc(1, 127, 0);
    repeat (300) cyc();
    cyc(1, 127, 2);
    count_to_tick("restart", 1024);

    // Asynchronous reset in the middle of a period.
    repeat (37) cyc();
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out", out, 0);
    check_val("midrst_ptick", period_tick, 0);
    model_init();
    @(negedge clk);
    check_val("midrst_hold", out, 0);
    rst_n = 1'b1;
    count_to_tick("post_reset", 256);

    // Randomised operation.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        ch = $urandom_range(0, N - 1);
        v  = $urandom_range(0, 4);
        v  = (v == 0) ? 0 : (v == 1) ? 255 : $urandom_range(0, 255);
        cyc(1, ch, v);
      end else if (r == 4) begin
        out_en = N'($urandom); pwm_en = N'($urandom);
      end else if (r == 5) begin
        cyc(1, 127, 0);
        cyc(1, 126, $urandom_range(0, 2));
        cyc(1, 127, 2 | $urandom_range(0, 1));
      end else if (r == 6) begin
        cyc(1, 127, 0);
        repeat ($urandom_range(1, 50)) cyc();
        cyc(1, 127, 2);
      end else if (r == 7) begin
        cyc(1, $urandom_range(N, 125), $urandom_range(0, 255));
      end
      repeat ($urandom_range(1, 400)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
